// File: rtl/hello_seq_pkg.sv
// Shared types and helpers for the hello ROM sequencer and its gap timer.
package hello_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REWIND = 3'd1,
      S_FETCH  = 3'd2,
      S_LOAD   = 3'd3,
      S_SEND   = 3'd4,
      S_GAP    = 3'd5
   } state_t;

   // Bits needed to hold GAP-1; never narrower than one bit.
   function automatic int gapWidth(input int gap);
      return (gap > 1) ? $clog2(gap) : 1;
   endfunction

endpackage

// File: rtl/hello_gap_timer.sv
// Loadable down-counter with a zero flag, used to time the idle gap between
// message repetitions.
module hello_gap_timer
   import hello_seq_pkg::*;
#(
   parameter int GW = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load_i,
   input  logic          en_i,
   input  logic [GW-1:0] value_i,
   output logic          zero_o
);

   logic [GW-1:0] cnt_q;

   // Load has priority over the decrement; the counter parks at zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= value_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - GW'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hello_seq.sv
// Sequencer that rewinds the hello ROM, streams its words to a valid/ready
// sink, and repeats the message count times with an idle gap in between.
module hello_seq
   import hello_seq_pkg::*;
#(
   parameter int W   = 8,
   parameter int CW  = 8,
   parameter int GAP = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic [CW-1:0] count,
   output logic          busy,
   output logic          done,
   output logic          rom_rewind,
   output logic          rom_get,
   input  logic [W-1:0]  rom_out,
   input  logic          rom_empty,
   output logic [W-1:0]  tx_data,
   output logic          tx_valid,
   input  logic          tx_ready
);

   localparam int GW = gapWidth(GAP);
   localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

   state_t        state_q, state_d;
   logic [CW-1:0] rem_q, rem_d;
   logic          cont_q, cont_d;
   logic          stopPend_q, stopPend_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [W-1:0]  txData_q, txData_d;
   logic          txValid_q, txValid_d;

   logic          gapLoad, gapEn, gapZero, goIdle, stopNow;

   hello_gap_timer #(.GW(GW)) uGapTimer (
      .clock   (clock),
      .reset   (reset),
      .load_i  (gapLoad),
      .en_i    (gapEn),
      .value_i (GAP_LOAD),
      .zero_o  (gapZero)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rem_q      <= '0;
         cont_q     <= 1'b0;
         stopPend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         txData_q   <= '0;
         txValid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         cont_q     <= cont_d;
         stopPend_q <= stopPend_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         txData_q   <= txData_d;
         txValid_q  <= txValid_d;
      end
   end

   // A stop seen this cycle acts like one already pending, so a stop that
   // lands on a handshake cycle still ends the run at that byte boundary.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      cont_d     = cont_q;
      stopPend_d = stopPend_q | ((state_q != S_IDLE) & stop);
      busy_d     = busy_q;
      done_d     = 1'b0;
      txData_d   = txData_q;
      txValid_d  = txValid_q;
      rom_rewind = 1'b0;
      rom_get    = 1'b0;
      gapLoad    = 1'b0;
      gapEn      = 1'b0;
      goIdle     = 1'b0;
      stopNow    = stopPend_q | stop;

      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               rem_d   = count;
               cont_d  = (count == '0);
               busy_d  = 1'b1;
               state_d = S_REWIND;
            end
         end
         S_REWIND: begin
            rom_rewind = 1'b1;
            state_d    = S_FETCH;
         end
         S_FETCH: begin
            if (stopNow) begin
               goIdle = 1'b1;
            end else if (rom_empty) begin
               if (!cont_q && (rem_q != '0)) begin
                  rem_d = rem_q - CW'(1);
               end
               if (!cont_q && (rem_q == CW'(1))) begin
                  goIdle = 1'b1;
               end else if (GAP == 0) begin
                  state_d = S_REWIND;
               end else begin
                  gapLoad = 1'b1;
                  state_d = S_GAP;
               end
            end else begin
               rom_get = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            txData_d  = rom_out;
            txValid_d = 1'b1;
            state_d   = S_SEND;
         end
         S_SEND: begin
            if (tx_ready) begin
               txValid_d = 1'b0;
               if (stopNow) begin
                  goIdle = 1'b1;
               end else if (!rom_empty) begin
                  rom_get = 1'b1;
                  state_d = S_LOAD;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_GAP: begin
            gapEn = 1'b1;
            if (stopNow) begin
               goIdle = 1'b1;
            end else if (gapZero) begin
               state_d = S_REWIND;
            end
         end
         default: begin
            goIdle = 1'b1;
         end
      endcase

      if (goIdle) begin
         state_d    = S_IDLE;
         busy_d     = 1'b0;
         done_d     = 1'b1;
         stopPend_d = 1'b0;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign tx_data  = txData_q;
   assign tx_valid = txValid_q;

endmodule

// File: tb/tb_hello_seq.sv
// Directed bench for hello_seq against a behavioural model of the sequential
// "hello\r\n" ROM, with a 4-cycle repetition gap.
module tb_hello_seq;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] count = 8'd0;
   logic       busy, done, rom_rewind, rom_get, tx_valid;
   logic [7:0] rom_out, tx_data;
   logic       rom_empty;
   logic       tx_ready = 1'b1;

   int total = 0;
   int bad = 0;

   logic [7:0] romMem [0:6] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
   int         romIdx;

   logic [7:0] xferQ[$];
   int         xferCyc[$];
   int         rewQ[$];
   int         getCount = 0;
   int         doneCount = 0;
   int         cycNum = 0;

   hello_seq #(.W(8), .CW(8), .GAP(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .rom_rewind (rom_rewind),
      .rom_get    (rom_get),
      .rom_out    (rom_out),
      .rom_empty  (rom_empty),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready)
   );

   always #5 clock = ~clock;

   // Sequential ROM: registered word on get, index cleared by reset or rewind.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         romIdx  <= 0;
         rom_out <= 8'h00;
      end else if (rom_rewind) begin
         romIdx <= 0;
      end else if (rom_get) begin
         rom_out <= romMem[romIdx % 7];
         romIdx  <= romIdx + 1;
      end
   end
   assign rom_empty = (romIdx >= 7);

   // Event log of transfers, rewinds, fetches and done pulses.
   always @(posedge clock) begin
      if (tx_valid && tx_ready) begin
         xferQ.push_back(tx_data);
         xferCyc.push_back(cycNum);
      end
      if (rom_rewind) rewQ.push_back(cycNum);
      if (rom_get) getCount <= getCount + 1;
      if (done) doneCount <= doneCount + 1;
      cycNum <= cycNum + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic pulseStart(input logic [7:0] n);
      count = n;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int maxCyc);
      int n = 0;
      while (done !== 1'b1 && n < maxCyc) begin
         cyc();
         n++;
      end
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic waitXfers(input string tag, input int target, input int maxCyc);
      int n = 0;
      while (xferQ.size() < target && n < maxCyc) begin
         cyc();
         n++;
      end
      check({tag, "_reach"}, xferQ.size(), target);
   endtask

   initial begin
      int xb, rb, gb, db;
      logic [7:0] held;
      logic heldFlag;

      // Reset state
      cyc();
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_rewind", {31'd0, rom_rewind}, 0);
      check("rst_get", {31'd0, rom_get}, 0);
      check("rst_valid", {31'd0, tx_valid}, 0);
      check("rst_data", {24'd0, tx_data}, 0);
      reset = 1'b0;
      cyc();

      // Single message, sink always ready
      xb = xferQ.size(); rb = rewQ.size();
      pulseStart(8'd1);
      check("t1_busy", {31'd0, busy}, 1);
      check("t1_rewind", {31'd0, rom_rewind}, 1);
      waitDone("t1", 100);
      cyc();
      check("t1_done_once", {31'd0, done}, 0);
      check("t1_count", xferQ.size() - xb, 7);
      for (int i = 0; i < 7; i++) check($sformatf("t1_byte%0d", i), {24'd0, xferQ[xb + i]}, {24'd0, romMem[i]});
      check("t1_span", xferCyc[xb + 6] - xferCyc[xb], 12);
      check("t1_first_lat", xferCyc[xb] - rewQ[rb], 3);

      // Two messages, sink stalls 3 cycles on byte 3
      xb = xferQ.size(); rb = rewQ.size();
      tx_ready = 1'b1;
      pulseStart(8'd2);
      begin
         int n = 0;
         while (!(xferQ.size() - xb == 2 && tx_valid) && n < 50) begin
            cyc();
            n++;
         end
      end
      check("t2_at_byte3", {31'd0, tx_valid}, 1);
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check($sformatf("t2_hold_data%0d", i), {24'd0, tx_data}, 32'h6C);
         check($sformatf("t2_hold_valid%0d", i), {31'd0, tx_valid}, 1);
      end
      tx_ready = 1'b1;
      waitDone("t2", 200);
      check("t2_count", xferQ.size() - xb, 14);
      for (int i = 0; i < 14; i++) check($sformatf("t2_byte%0d", i), {24'd0, xferQ[xb + i]}, {24'd0, romMem[i % 7]});
      check("t2_rewinds", rewQ.size() - rb, 2);
      if (rewQ.size() - rb >= 2 && xferQ.size() - xb >= 7)
         check("t2_gap", rewQ[rb + 1] - xferCyc[xb + 6], 6);

      // Endless run stopped after 10 transfers
      cyc();
      xb = xferQ.size(); gb = getCount;
      pulseStart(8'd0);
      waitXfers("t3", xb + 10, 300);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      waitDone("t3", 50);
      cyc();
      check("t3_count", xferQ.size() - xb, 11);
      check("t3_byte11", {24'd0, xferQ[xferQ.size() - 1]}, 32'h6C);
      check("t3_gets", getCount - gb, 11);

      // Start while busy, and start+stop together in idle, are ignored
      xb = xferQ.size(); rb = rewQ.size(); db = doneCount;
      pulseStart(8'd1);
      repeat (5) cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      waitDone("t4", 100);
      cyc();
      start = 1'b1; stop = 1'b1;
      cyc();
      start = 1'b0; stop = 1'b0;
      check("t4_idle_busy", {31'd0, busy}, 0);
      repeat (3) cyc();
      check("t4_count", xferQ.size() - xb, 7);
      check("t4_rewinds", rewQ.size() - rb, 1);
      check("t4_dones", doneCount - db, 1);
      check("t4_busy", {31'd0, busy}, 0);

      // Async reset in the middle of a byte
      pulseStart(8'd1);
      begin
         int n = 0;
         while (!tx_valid && n < 20) begin
            cyc();
            n++;
         end
      end
      check("t5_valid_before", {31'd0, tx_valid}, 1);
      #2 reset = 1'b1;
      #1;
      check("t5_valid", {31'd0, tx_valid}, 0);
      check("t5_busy", {31'd0, busy}, 0);
      check("t5_data", {24'd0, tx_data}, 0);
      check("t5_get", {31'd0, rom_get}, 0);
      check("t5_rewind", {31'd0, rom_rewind}, 0);
      check("t5_done", {31'd0, done}, 0);
      cyc();
      reset = 1'b0;
      cyc();
      xb = xferQ.size();
      pulseStart(8'd1);
      waitXfers("t5", xb + 1, 30);
      check("t5_first", {24'd0, xferQ[xb]}, 32'h68);
      waitDone("t5", 100);

      // Random sink backpressure
      cyc();
      xb = xferQ.size();
      pulseStart(8'd1);
      heldFlag = 1'b0;
      held = 8'h00;
      begin
         int n = 0;
         while (busy && n < 400) begin
            tx_ready = 1'($urandom_range(0, 1));
            heldFlag = tx_valid && !tx_ready;
            held = tx_data;
            cyc();
            if (heldFlag) check("t6_stable", {24'd0, tx_data}, {24'd0, held});
            n++;
         end
      end
      check("t6_finished", {31'd0, busy}, 0);
      tx_ready = 1'b1;
      cyc();
      check("t6_count", xferQ.size() - xb, 7);
      for (int i = 0; i < 7; i++) check($sformatf("t6_byte%0d", i), {24'd0, xferQ[xb + i]}, {24'd0, romMem[i]});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
